// File: rtl/minicpu_seq.sv
// MiniCPU instruction sequencer and memory controller: fetch/decode, ALU strobes, Req/Ack cycles.
// Define MINICPU_SEQ_TRAP_EN to make reserved EXE opcodes run a JSR to TRAP_VEC.
module minicpu_seq #(
  parameter logic [11:0] RST_VEC  = 12'h000,
  parameter logic [11:0] TRAP_VEC = 12'hFF8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        CE,
  output logic        Req,
  output logic        WE,
  output logic        DS,
  output logic [11:0] AO,
  output logic [5:0]  DO,
  input  logic [5:0]  DI,
  input  logic        Ack,
  output logic [3:0]  ALU_I,
  output logic        ALU_Ld,
  output logic [5:0]  ALU_Op,
  output logic        ALU_CE,
  input  logic [5:0]  ALU_A,
  input  logic        ALU_Z
);

`ifdef MINICPU_SEQ_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StFetch, StDecode, StStWr, StLdRd, StJsrHi, StJsrLo, StRtsLo, StRtsHi
  } state_e;

  state_e      state_q;
  logic [11:0] i_q, w_q, op_q;
  logic [5:0]  ir_q;
  logic [11:0] ope;
  logic        exe_std;
  logic        alu_stb;

  assign ope     = {op_q[11:3], op_q[2:0] | ir_q[2:0]};
  assign exe_std = (ope[11:3] == 9'd0);
  assign ALU_Op  = ope[5:0];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StFetch;
      i_q     <= RST_VEC;
      w_q     <= 12'd0;
      op_q    <= 12'd0;
      ir_q    <= 6'd0;
    end else if (CE) begin
      unique case (state_q)
        StFetch: begin
          if (Ack) begin
            ir_q    <= DI;
            i_q     <= i_q + 12'd1;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          state_q <= StFetch;
          op_q    <= 12'd0;
          case (ir_q[5:3])
            3'b111: op_q <= {ope[8:0], 3'b000};
            3'b001: w_q <= ope;
            3'b110: ;
            3'b011: if (!ALU_Z) i_q <= i_q + ope;
            3'b100: begin
              op_q    <= ope;
              state_q <= StStWr;
            end
            3'b101: begin
              op_q    <= ope;
              state_q <= StLdRd;
            end
            3'b010: begin
              op_q    <= ope;
              w_q     <= w_q - 12'd1;
              state_q <= StJsrHi;
            end
            3'b000: begin
              if (exe_std) begin
                if (ope[2:0] == 3'b111) state_q <= StRtsLo;
              end else if (TrapEn) begin
                // Reserved EXE becomes a call; i_q already points past the EXE.
                op_q    <= TRAP_VEC;
                w_q     <= w_q - 12'd1;
                state_q <= StJsrHi;
              end
            end
          endcase
        end
        StStWr, StLdRd: begin
          if (Ack) begin
            op_q    <= 12'd0;
            state_q <= StFetch;
          end
        end
        StJsrHi: begin
          if (Ack) begin
            w_q     <= w_q - 12'd1;
            state_q <= StJsrLo;
          end
        end
        StJsrLo: begin
          if (Ack) begin
            i_q     <= op_q;
            op_q    <= 12'd0;
            state_q <= StFetch;
          end
        end
        StRtsLo: begin
          if (Ack) begin
            i_q[5:0] <= DI;
            w_q      <= w_q + 12'd1;
            state_q  <= StRtsHi;
          end
        end
        StRtsHi: begin
          if (Ack) begin
            i_q[11:6] <= DI;
            w_q       <= w_q + 12'd1;
            state_q   <= StFetch;
          end
        end
      endcase
    end
  end

  always_comb begin
    Req     = 1'b0;
    WE      = 1'b0;
    DS      = 1'b0;
    AO      = i_q;
    DO      = 6'd0;
    ALU_I   = 4'b0000;
    ALU_Ld  = 1'b0;
    alu_stb = 1'b0;
    unique case (state_q)
      StFetch: Req = 1'b1;
      StDecode: begin
        if (ir_q[5:3] == 3'b110) begin
          ALU_I   = 4'b0110;
          alu_stb = 1'b1;
        end else if (ir_q[5:3] == 3'b011) begin
          ALU_I   = 4'b0011;
          alu_stb = 1'b1;
        end else if (ir_q[5:3] == 3'b000 && exe_std && ope[2:0] != 3'b111) begin
          ALU_I   = {1'b1, ope[2:0]};
          alu_stb = 1'b1;
        end
      end
      StStWr: begin
        Req = 1'b1;
        WE  = 1'b1;
        DS  = 1'b1;
        AO  = w_q + op_q;
        DO  = ALU_A;
        if (Ack) begin
          ALU_I   = 4'b0100;
          alu_stb = 1'b1;
        end
      end
      StLdRd: begin
        Req = 1'b1;
        DS  = 1'b1;
        AO  = w_q + op_q;
        if (Ack) begin
          ALU_Ld  = 1'b1;
          alu_stb = 1'b1;
        end
      end
      StJsrHi, StJsrLo: begin
        Req = 1'b1;
        WE  = 1'b1;
        DS  = 1'b1;
        AO  = w_q;
        DO  = (state_q == StJsrHi) ? i_q[11:6] : i_q[5:0];
      end
      StRtsLo, StRtsHi: begin
        Req = 1'b1;
        DS  = 1'b1;
        AO  = w_q;
      end
    endcase
    // Reset aborts any cycle in flight, including an un-acked write.
    if (Rst) begin
      Req     = 1'b0;
      WE      = 1'b0;
      DS      = 1'b0;
      ALU_I   = 4'b0000;
      ALU_Ld  = 1'b0;
      alu_stb = 1'b0;
    end
  end

  assign ALU_CE = alu_stb & CE;

endmodule

// File: tb/tb_minicpu_seq.sv
// Bench for minicpu_seq: memory model with Ack delay, event scoreboard of transfers and ALU strobes.
module tb_minicpu_seq;
  logic        Clk = 1'b0;
  logic        Rst, CE, Ack, ALU_Z;
  logic [5:0]  DI, DO, ALU_A, ALU_Op;
  logic        Req, WE, DS, ALU_Ld, ALU_CE;
  logic [11:0] AO;
  logic [3:0]  ALU_I;

  always #5 Clk = ~Clk;

  minicpu_seq dut (
    .Clk(Clk), .Rst(Rst), .CE(CE), .Req(Req), .WE(WE), .DS(DS), .AO(AO), .DO(DO), .DI(DI),
    .Ack(Ack), .ALU_I(ALU_I), .ALU_Ld(ALU_Ld), .ALU_Op(ALU_Op), .ALU_CE(ALU_CE),
    .ALU_A(ALU_A), .ALU_Z(ALU_Z)
  );

  logic [5:0]  imem [4096];
  logic [5:0]  dmem [4096];
  int          ack_delay = 0;
  int          req_cnt = 0;
  logic        ack_block = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          obs_rd = 0;
  int          ld_hold_cnt = 0;
  int          ld_pulse_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  assign Ack = !ack_block && (req_cnt >= ack_delay);
  assign DI  = DS ? ((AO == 12'h012) ? 6'h17 : dmem[AO]) : imem[AO];

  always @(posedge Clk) begin
    if (Rst || !Req) req_cnt <= 0;
    else if (CE) begin
      if (Ack) begin
        req_cnt <= 0;
        if (WE && DS) dmem[AO] <= DO;
      end else req_cnt <= req_cnt + 1;
    end
  end

  function automatic logic [31:0] ev_xfer(input logic [3:0] kind, input logic [11:0] a,
                                          input logic [5:0] d);
    return {kind, 10'd0, a, d};
  endfunction

  function automatic logic [31:0] ev_alu(input logic [3:0] i, input logic ld, input logic [5:0] op);
    return {4'h1, 17'd0, i, ld, op};
  endfunction

  // kinds: 2 = data write, 3 = fetch, 4 = data read, 1 = ALU strobe
  always @(negedge Clk) begin
    if (!Rst) begin
      if (Req && Ack && CE)
        obs_q.push_back(WE ? ev_xfer(4'h2, AO, DO) : ev_xfer(DS ? 4'h4 : 4'h3, AO, 6'd0));
      if (ALU_CE) obs_q.push_back(ev_alu(ALU_I, ALU_Ld, ALU_Op));
      if (Req && DS && !WE && AO == 12'h012) ld_hold_cnt <= ld_hold_cnt + 1;
      if (ALU_Ld && ALU_CE) ld_pulse_cnt <= ld_pulse_cnt + 1;
    end
  end

  task automatic hold_reset;
    @(posedge Clk); #2;
    Rst = 1'b1; CE = 1'b1; ack_block = 1'b0; ack_delay = 0; ALU_Z = 1'b0;
    for (int a = 0; a < 4096; a++) imem[a] = 6'o70;
    exp_q.delete();
    repeat (2) @(posedge Clk);
    #2 obs_rd = obs_q.size();
  endtask

  task automatic release_reset;
    @(posedge Clk); #2 Rst = 1'b0;
  endtask

  task automatic wait_events(input int n, output bit to);
    int c = 0;
    while ((obs_q.size() - obs_rd) < n && c < 400) begin
      @(negedge Clk);
      c++;
    end
    to = ((obs_q.size() - obs_rd) < n);
  endtask

  task automatic test_reset;
    bit to;
    hold_reset();
    @(negedge Clk);
    checks++;
    if ({Req, WE, ALU_CE, ALU_Ld, DS, ALU_I} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, need 0", {Req, WE, ALU_CE, ALU_Ld, DS, ALU_I});
    end
    release_reset();
    #1;
    checks++;
    if ({Req, DS, WE, AO} !== {3'b100, 12'h000}) begin
      errors++;
      $display("FAIL reset_first_fetch: got Req=%b DS=%b WE=%b AO=%h, need 1 0 0 000",
               Req, DS, WE, AO);
    end
  endtask

  task automatic test_ldk_ce;
    bit to;
    logic [31:0] e;
    hold_reset();
    imem[0] = 6'o65;
    exp_q.push_back(ev_xfer(4'h3, 12'h000, 6'd0));
    exp_q.push_back(ev_alu(4'b0110, 1'b0, 6'd5));
    exp_q.push_back(ev_xfer(4'h3, 12'h001, 6'd0));
    release_reset();
    @(posedge Clk); #1 CE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checks++;
      if (ALU_CE !== 1'b0 || ALU_I !== 4'b0110) begin
        errors++;
        $display("FAIL ce_freeze: got ALU_CE=%b ALU_I=%b, need 0 0110", ALU_CE, ALU_I);
      end
    end
    @(posedge Clk); #1 CE = 1'b1;
    #1;
    checks++;
    if (ALU_CE !== 1'b1) begin
      errors++;
      $display("FAIL ce_resume: got ALU_CE=%b, need 1", ALU_CE);
    end
    wait_events(exp_q.size(), to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL ldk_events: got %0d events, need %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL ldk_ev: got %h, need %h", obs_q[obs_rd], e);
      end
      obs_rd++;
    end
  endtask

  task automatic test_prefix_ldw;
    bit to;
    logic [31:0] e;
    hold_reset();
    imem[0] = 6'o71; imem[1] = 6'o72; imem[2] = 6'o13; imem[3] = 6'o40;
    for (int a = 0; a < 4; a++) exp_q.push_back(ev_xfer(4'h3, 12'(a), 6'd0));
    exp_q.push_back(ev_xfer(4'h2, 12'h053, 6'h2A));
    exp_q.push_back(ev_alu(4'b0100, 1'b0, 6'd0));
    exp_q.push_back(ev_xfer(4'h3, 12'h004, 6'd0));
    release_reset();
    wait_events(exp_q.size(), to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL pfx_events: got %0d events, need %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL pfx_ev: got %h, need %h", obs_q[obs_rd], e);
      end
      obs_rd++;
    end
  endtask

  task automatic test_ld_wait;
    bit to;
    logic [31:0] e;
    int hold0, pulse0;
    hold_reset();
    ack_delay = 3;
    imem[0] = 6'o72; imem[1] = 6'o10; imem[2] = 6'o52;
    for (int a = 0; a < 3; a++) exp_q.push_back(ev_xfer(4'h3, 12'(a), 6'd0));
    exp_q.push_back(ev_xfer(4'h4, 12'h012, 6'd0));
    exp_q.push_back(ev_alu(4'b0000, 1'b1, 6'd2));
    exp_q.push_back(ev_xfer(4'h3, 12'h003, 6'd0));
    hold0 = ld_hold_cnt;
    pulse0 = ld_pulse_cnt;
    release_reset();
    wait_events(exp_q.size(), to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL ld_events: got %0d events, need %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL ld_ev: got %h, need %h", obs_q[obs_rd], e);
      end
      obs_rd++;
    end
    checks++;
    if (ld_hold_cnt - hold0 != 4) begin
      errors++;
      $display("FAIL ld_hold: got %0d cycles, need 4", ld_hold_cnt - hold0);
    end
    checks++;
    if (ld_pulse_cnt - pulse0 != 1) begin
      errors++;
      $display("FAIL ld_pulse: got %0d pulses, need 1", ld_pulse_cnt - pulse0);
    end
  endtask

  task automatic test_jsr_rts;
    bit to;
    logic [31:0] e;
    hold_reset();
    imem[0] = 6'o74; imem[1] = 6'o10; imem[2] = 6'o73; imem[3] = 6'o77; imem[4] = 6'o34;
    imem[12'h101] = 6'o71; imem[12'h102] = 6'o70; imem[12'h103] = 6'o70;
    imem[12'h104] = 6'o20; imem[12'h200] = 6'o07; imem[12'h105] = 6'o40;
    for (int a = 0; a < 5; a++) exp_q.push_back(ev_xfer(4'h3, 12'(a), 6'd0));
    exp_q.push_back(ev_alu(4'b0011, 1'b0, 6'h3C));
    for (int a = 12'h101; a < 12'h105; a++) exp_q.push_back(ev_xfer(4'h3, 12'(a), 6'd0));
    exp_q.push_back(ev_xfer(4'h2, 12'h01F, 6'h04));
    exp_q.push_back(ev_xfer(4'h2, 12'h01E, 6'h05));
    exp_q.push_back(ev_xfer(4'h3, 12'h200, 6'd0));
    exp_q.push_back(ev_xfer(4'h4, 12'h01E, 6'd0));
    exp_q.push_back(ev_xfer(4'h4, 12'h01F, 6'd0));
    exp_q.push_back(ev_xfer(4'h3, 12'h105, 6'd0));
    exp_q.push_back(ev_xfer(4'h2, 12'h020, 6'h2A));
    exp_q.push_back(ev_alu(4'b0100, 1'b0, 6'd0));
    exp_q.push_back(ev_xfer(4'h3, 12'h106, 6'd0));
    release_reset();
    wait_events(exp_q.size(), to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL jsr_events: got %0d events, need %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL jsr_ev: got %h, need %h", obs_q[obs_rd], e);
      end
      obs_rd++;
    end
  endtask

  task automatic test_cj(input logic z);
    bit to;
    logic [31:0] e;
    hold_reset();
    ALU_Z = z;
    imem[0] = 6'o73; imem[1] = 6'o77; imem[2] = 6'o26;
    imem[12'h0FE] = 6'o71; imem[12'h0FF] = 6'o30;
    for (int a = 0; a < 3; a++) exp_q.push_back(ev_xfer(4'h3, 12'(a), 6'd0));
    exp_q.push_back(ev_xfer(4'h2, 12'hFFF, 6'h00));
    exp_q.push_back(ev_xfer(4'h2, 12'hFFE, 6'h03));
    exp_q.push_back(ev_xfer(4'h3, 12'h0FE, 6'd0));
    exp_q.push_back(ev_xfer(4'h3, 12'h0FF, 6'd0));
    exp_q.push_back(ev_alu(4'b0011, 1'b0, 6'd8));
    exp_q.push_back(ev_xfer(4'h3, z ? 12'h100 : 12'h108, 6'd0));
    release_reset();
    wait_events(exp_q.size(), to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL cj_events z=%b: got %0d events, need %0d", z, obs_q.size() - obs_rd,
               exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL cj_ev z=%b: got %h, need %h", z, obs_q[obs_rd], e);
      end
      obs_rd++;
    end
  endtask

  task automatic test_rst_mid_store;
    int c = 0;
    int wr = 0;
    hold_reset();
    ack_delay = 2;
    imem[0] = 6'o40;
    release_reset();
    while (!(Req && WE) && c < 30) begin
      @(negedge Clk);
      c++;
    end
    ack_block = 1'b1;
    checks++;
    if (!(Req && WE)) begin
      errors++;
      $display("FAIL rst_st_reach: got Req=%b WE=%b, need 1 1", Req, WE);
    end
    @(posedge Clk); #2;
    checks++;
    if (WE !== 1'b1 || AO !== 12'h000) begin
      errors++;
      $display("FAIL rst_st_stall: got WE=%b AO=%h, need 1 000", WE, AO);
    end
    Rst = 1'b1;
    #1;
    checks++;
    if (WE !== 1'b0 || Req !== 1'b0) begin
      errors++;
      $display("FAIL rst_st_abort: got WE=%b Req=%b, need 0 0", WE, Req);
    end
    @(posedge Clk); #2;
    ack_block = 1'b0;
    ack_delay = 0;
    Rst = 1'b0;
    #1;
    checks++;
    if ({Req, WE, DS, AO} !== {3'b100, 12'h000}) begin
      errors++;
      $display("FAIL rst_st_refetch: got Req=%b WE=%b DS=%b AO=%h, need 1 0 0 000",
               Req, WE, DS, AO);
    end
    for (int k = obs_rd; k < obs_q.size(); k++) if (obs_q[k][31:28] == 4'h2) wr++;
    checks++;
    if (wr != 0) begin
      errors++;
      $display("FAIL rst_st_nowrite: got %0d writes, need 0", wr);
    end
  endtask

  task automatic test_trap;
    bit to;
    logic [31:0] e;
    hold_reset();
    imem[0] = 6'o71; imem[1] = 6'o70; imem[2] = 6'o20;
    imem[12'h040] = 6'o71; imem[12'h041] = 6'o00; imem[12'h042] = 6'o40;
    for (int a = 0; a < 3; a++) exp_q.push_back(ev_xfer(4'h3, 12'(a), 6'd0));
    exp_q.push_back(ev_xfer(4'h2, 12'hFFF, 6'h00));
    exp_q.push_back(ev_xfer(4'h2, 12'hFFE, 6'h03));
    exp_q.push_back(ev_xfer(4'h3, 12'h040, 6'd0));
    exp_q.push_back(ev_xfer(4'h3, 12'h041, 6'd0));
`ifdef MINICPU_SEQ_TRAP_EN
    exp_q.push_back(ev_xfer(4'h2, 12'hFFD, 6'h01));
    exp_q.push_back(ev_xfer(4'h2, 12'hFFC, 6'h02));
    exp_q.push_back(ev_xfer(4'h3, 12'hFF8, 6'd0));
`else
    exp_q.push_back(ev_xfer(4'h3, 12'h042, 6'd0));
    exp_q.push_back(ev_xfer(4'h2, 12'hFFE, 6'h2A));
    exp_q.push_back(ev_alu(4'b0100, 1'b0, 6'd0));
    exp_q.push_back(ev_xfer(4'h3, 12'h043, 6'd0));
`endif
    release_reset();
    wait_events(exp_q.size(), to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL trap_events: got %0d events, need %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL trap_ev: got %h, need %h", obs_q[obs_rd], e);
      end
      obs_rd++;
    end
  endtask

  initial begin
    Rst = 1'b1; CE = 1'b1; ALU_Z = 1'b0; ALU_A = 6'h2A;
    test_reset();
    test_ldk_ce();
    test_prefix_ldw();
    test_ld_wait();
    test_jsr_rts();
    test_cj(1'b0);
    test_cj(1'b1);
    test_rst_mid_store();
    test_trap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/minicpu_seq.md
Name: minicpu_seq

Overview:
Instruction sequencer and memory controller for the MiniCPU. It drives the ALU's control inputs (instruction code, load strobe, operand, clock enable) and owns I (instruction pointer), W (workspace pointer), Op (operand/prefix register) and IR. It fetches 6-bit instructions, executes the eight direct instructions and the Class 1 indirect instructions, and runs all external memory cycles through a Req/Ack handshake.

Parameters:
RST_VEC, 12'h000, I value loaded on reset.
TRAP_VEC, 12'hFF8, target address of the reserved-opcode trap (optional feature only).

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
CE  in  1  module clock enable; no state or register change while low
Req  out  1  memory request; held until the Ack cycle
WE  out  1  write strobe, qualified by Req
DS  out  1  address space: 0 = instruction (read-only), 1 = data
AO  out  12  memory address
DO  out  6  write data
DI  in  6  read data; also wired to the ALU DI input
Ack  in  1  memory ready; a transfer completes on a cycle with Req & Ack & CE
ALU_I  out  4  ALU instruction code
ALU_Ld  out  1  push DI onto the ALU stack
ALU_Op  out  6  ALU operand (OpE[5:0])
ALU_CE  out  1  ALU clock enable, single-cycle strobe, qualified by CE
ALU_A  in  6  ALU TOS, used as ST data
ALU_Z  in  1  ALU TOS == 0

Behaviour:
- Reset: I = RST_VEC, W = 0, Op = 0, IR = 0, state = FETCH. While Rst is high: Req, WE, ALU_CE, ALU_Ld = 0; ALU_I = 4'b0000; DS = 0. Outputs are combinational decodes of state and registers.
- Effective operand: OpE = {Op[11:3], Op[2:0] | IR[2:0]}.
- FETCH: Req = 1, DS = 0, AO = I. On Ack: IR <= DI, I <= I+1, go to DECODE.
- DECODE (1 cycle, on IR[5:3]):
  - 111 PFX: Op <= {OpE[8:0], 3'b000}.
  - 001 LDW: W <= OpE.
  - 110 LDK: ALU_I = 0110, ALU_CE = 1.
  - 011 CJ: if ~ALU_Z then I <= I + OpE (I already incremented). ALU_I = 0011, ALU_CE = 1 (pop).
  - 100 ST: Op <= OpE, go to ST_WR.
  - 101 LD: Op <= OpE, go to LD_RD.
  - 010 JSR: Op <= OpE, W <= W-1, go to JSR_HI.
  - 000 EXE, with OpE[11:3] == 0:
    - OpE[2:0] = 000..110: ALU_I = {1, OpE[2:0]}, ALU_CE = 1.
    - OpE[2:0] = 111 (RTS): go to RTS_LO.
  - 000 EXE, with OpE[11:3] != 0: reserved; treated as NOP.
  - Single-cycle instructions (all except PFX) clear Op and return to FETCH. PFX returns to FETCH with Op retained.
- ST_WR: Req = 1, WE = 1, DS = 1, AO = W+Op, DO = ALU_A. On Ack: ALU_I = 0100, ALU_CE = 1, Op <= 0, go to FETCH.
- LD_RD: Req = 1, DS = 1, AO = W+Op. On Ack: ALU_Ld = 1, ALU_CE = 1, Op <= 0, go to FETCH.
- JSR_HI: write I[11:6] at W. On Ack: W <= W-1, go to JSR_LO.
- JSR_LO: write I[5:0] at W. On Ack: I <= Op, Op <= 0, go to FETCH. Net effect: W decreases by 2, hi byte at old W-1, lo byte at old W-2.
- RTS_LO: read at W. On Ack: I[5:0] <= DI, W <= W+1, go to RTS_HI.
- RTS_HI: read at W. On Ack: I[11:6] <= DI, W <= W+1, go to FETCH.
- Arithmetic: all 12-bit address arithmetic wraps modulo 4096 (W+Op, I+1, I+Op, W±1).
- Wait states: while Req is high and Ack is low, AO, DS, WE and DO hold stable; no register changes.
- CE low: everything freezes. Outputs hold, but ALU_CE is forced 0 so the ALU never sees a stale or duplicated strobe.
- ALU_Op = OpE[5:0] in all states. ALU_I = 0000 and ALU_CE = 0 outside strobe cycles.
- Rst mid-cycle (including an un-Acked write): abort at once. WE drops the same cycle and no partial register update occurs.

Optional Feature:
MINICPU_SEQ_TRAP_EN
- Defined: EXE with OpE[11:3] != 0 runs the JSR sequence (JSR_HI, JSR_LO) with target TRAP_VEC. It pushes the address of the instruction following the EXE.
- Undefined: reserved EXE is a single-cycle NOP that clears Op.

Test Plan:
- Reset with RST_VEC = 12'h000, Ack tied high: first request is DS = 0, AO = 0. Program LDK 5 (6'o65) → ALU_I = 0110, ALU_CE pulse, ALU_Op = 5, I = 1.
- PFX 1 (6'o71), PFX 2 (6'o72), LDW 3 (6'o13) → W = 12'h053 (Op = 12'o123 = 12'h053); Op = 0 afterward.
- W = 12'h010, LD 2 with Ack delayed 3 cycles → AO = 12'h012 and DS = 1 held stable for 4 cycles; ALU_Ld and ALU_CE pulse exactly once, on the Ack cycle.
- W = 12'h020, I = 12'h105 after fetch, JSR to 12'h200 → writes 6'h04 at 12'h01F, then 6'h05 at 12'h01E; I = 12'h200, W = 12'h01E. Following RTS → I = 12'h105, W = 12'h020.
- CJ with ALU_Z = 0, prefixed offset 12'h008, CJ at address 12'h0FF → I = 12'h108. Repeat with ALU_Z = 1 → I = 12'h100. Pop strobe ALU_I = 0011 issued in both cases.
- Assert Rst during ST_WR with Ack low → WE = 0 the same cycle; next request is a FETCH at RST_VEC. With MINICPU_SEQ_TRAP_EN, PFX 1 then EXE at 12'h040 → pushes 12'h042, I = TRAP_VEC.
